// File: rtl/conv_mac_acc.sv
// Convolution multiply-accumulate engine: LANES parallel output features, one
// operand beat per cycle, fixed-point bias, optional ReLU and saturated output.
module conv_mac_lane #(
    parameter int DATA_W    = 16,
    parameter int FRAC_BITS = 8,
    parameter int ACC_W     = 2*DATA_W+8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     p_load_i,
    input  logic                     bias_load_i,
    input  logic                     acc_en_i,
    input  logic                     acc_first_i,
    input  logic                     out_load_i,
    input  logic                     relu_i,
    input  logic signed [DATA_W-1:0] act_i,
    input  logic signed [DATA_W-1:0] wgt_i,
    input  logic signed [DATA_W-1:0] bias_i,
    output logic signed [DATA_W-1:0] res_o,
    output logic                     sat_o
);
    localparam logic signed [ACC_W-1:0] MAXV = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] MINV = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    logic signed [2*DATA_W-1:0] p_q;
    logic signed [DATA_W-1:0]   bias_q;
    logic signed [ACC_W-1:0]    acc_q, acc_d, base, p_ext, r_shift, r_relu;
    logic signed [DATA_W-1:0]   res_q, res_d;
    logic                       sat_d;

    always_comb begin
        p_ext   = {{(ACC_W-2*DATA_W){p_q[2*DATA_W-1]}}, p_q};
        base    = acc_first_i ? ({{(ACC_W-DATA_W){bias_q[DATA_W-1]}}, bias_q} <<< FRAC_BITS)
                              : acc_q;
        acc_d   = base + p_ext;
        r_shift = acc_q >>> FRAC_BITS;
        r_relu  = (relu_i && r_shift[ACC_W-1]) ? '0 : r_shift;
        res_d   = r_relu[DATA_W-1:0];
        sat_d   = 1'b0;
        if (r_relu > MAXV) begin
            res_d = MAXV[DATA_W-1:0];
            sat_d = 1'b1;
        end else if (r_relu < MINV) begin
            res_d = MINV[DATA_W-1:0];
            sat_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_q    <= '0;
            bias_q <= '0;
            acc_q  <= '0;
            res_q  <= '0;
        end else begin
            if (p_load_i)    p_q    <= (2*DATA_W)'(act_i) * (2*DATA_W)'(wgt_i);
            if (bias_load_i) bias_q <= bias_i;
            if (acc_en_i)    acc_q  <= acc_d;
            if (out_load_i)  res_q  <= res_d;
        end
    end

    assign res_o = res_q;
    assign sat_o = sat_d;
endmodule

module conv_mac_acc #(
    parameter int LANES     = 8,
    parameter int DATA_W    = 16,
    parameter int FRAC_BITS = 8,
    parameter int ACC_W     = 2*DATA_W+8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic                    s_first,
    input  logic                    s_last,
    input  logic [LANES*DATA_W-1:0] s_act,
    input  logic [LANES*DATA_W-1:0] s_wgt,
    input  logic [LANES*DATA_W-1:0] s_bias,
    input  logic                    relu_en,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [LANES*DATA_W-1:0] m_data,
    output logic                    m_sat,
    output logic                    err
);
    typedef enum logic [1:0] {S_IDLE, S_ACC, S_FLUSH, S_OUT} state_t;

    state_t state_q;
    logic   p_vld_q, p_first_q, p_last_q, relu_q;
    logic   m_valid_q, m_sat_q, err_q;
    logic   accept, take, out_load;
    logic [LANES-1:0][DATA_W-1:0] lane_res;
    logic [LANES-1:0]             lane_sat;

    assign s_ready  = (state_q == S_IDLE) || (state_q == S_ACC);
    assign accept   = s_valid && s_ready;
    // Beats without s_first while idle are dropped before reaching the multiplier.
    assign take     = accept && ((state_q == S_ACC) || s_first);
    // Output registers load on the first OUT cycle, once the final product is in acc.
    assign out_load = (state_q == S_OUT) && !m_valid_q;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        conv_mac_lane #(
            .DATA_W(DATA_W), .FRAC_BITS(FRAC_BITS), .ACC_W(ACC_W)
        ) u_lane (
            .clk        (clk),
            .rst_n      (rst_n),
            .p_load_i   (take),
            .bias_load_i(take && s_first),
            .acc_en_i   (p_vld_q),
            .acc_first_i(p_first_q),
            .out_load_i (out_load),
            .relu_i     (relu_q),
            .act_i      (s_act[l*DATA_W +: DATA_W]),
            .wgt_i      (s_wgt[l*DATA_W +: DATA_W]),
            .bias_i     (s_bias[l*DATA_W +: DATA_W]),
            .res_o      (lane_res[l]),
            .sat_o      (lane_sat[l])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            p_vld_q   <= 1'b0;
            p_first_q <= 1'b0;
            p_last_q  <= 1'b0;
            relu_q    <= 1'b0;
            m_valid_q <= 1'b0;
            m_sat_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            p_vld_q <= take;
            if (take) begin
                p_first_q <= s_first;
                p_last_q  <= s_last;
            end
            if (take && s_first) relu_q <= relu_en;
            err_q <= accept && (((state_q == S_IDLE) && !s_first) ||
                                ((state_q == S_ACC) && s_first));
            case (state_q)
                S_IDLE: if (accept && s_first) state_q <= s_last ? S_FLUSH : S_ACC;
                S_ACC:  if (accept && s_last)  state_q <= S_FLUSH;
                S_FLUSH: if (p_vld_q && p_last_q) state_q <= S_OUT;
                S_OUT: begin
                    if (!m_valid_q) begin
                        m_valid_q <= 1'b1;
                        m_sat_q   <= |lane_sat;
                    end else if (m_ready) begin
                        m_valid_q <= 1'b0;
                        state_q   <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign m_valid = m_valid_q;
    assign m_sat   = m_sat_q;
    assign m_data  = lane_res;
    assign err     = err_q;
endmodule

// File: tb/tb_conv_mac_acc.sv
// Bench for conv_mac_acc: directed and random pixels against an integer-arithmetic model.
module tb_conv_mac_acc;
    localparam int LANES = 8;
    localparam int DW    = 16;
    localparam int FB    = 8;
    localparam int MAXB  = 16;

    logic clk = 0, rst_n = 0;
    logic s_valid = 0, s_ready, s_first = 0, s_last = 0, relu_en = 0;
    logic [LANES*DW-1:0] s_act = '0, s_wgt = '0, s_bias = '0, m_data;
    logic m_valid, m_ready = 0, m_sat, err;

    int tests = 0, fails = 0;

    logic signed [DW-1:0] act_a [LANES][MAXB];
    logic signed [DW-1:0] wgt_a [LANES][MAXB];
    logic signed [DW-1:0] bias_a[LANES];

    conv_mac_acc dut (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready),
        .s_first(s_first), .s_last(s_last), .s_act(s_act), .s_wgt(s_wgt),
        .s_bias(s_bias), .relu_en(relu_en), .m_valid(m_valid), .m_ready(m_ready),
        .m_data(m_data), .m_sat(m_sat), .err(err)
    );

    always #5 clk = ~clk;

    // Result = floor((bias*2^FB + sum(act*wgt)) / 2^FB), optional ReLU, clamp to DW bits.
    function automatic void model(input int nb, input bit relu,
                                  output logic [LANES*DW-1:0] exp_d, output logic exp_sat);
        longint acc, r;
        exp_sat = 0;
        exp_d   = '0;
        for (int l = 0; l < LANES; l++) begin
            acc = longint'(bias_a[l]) * (64'sd1 <<< FB);
            for (int b = 0; b < nb; b++) acc += longint'(act_a[l][b]) * longint'(wgt_a[l][b]);
            r = acc >>> FB;
            if (relu && r < 0) r = 0;
            if (r > 32767) begin r = 32767; exp_sat = 1; end
            if (r < -32768) begin r = -32768; exp_sat = 1; end
            exp_d[l*DW +: DW] = DW'(r);
        end
    endfunction

    task automatic fill(input int nb, input logic [DW-1:0] a, input logic [DW-1:0] w,
                        input logic [DW-1:0] bs);
        for (int l = 0; l < LANES; l++) begin
            bias_a[l] = bs;
            for (int b = 0; b < nb; b++) begin act_a[l][b] = a; wgt_a[l][b] = w; end
        end
    endtask

    task automatic fill_rand(input int nb);
        for (int l = 0; l < LANES; l++) begin
            bias_a[l] = DW'($urandom);
            for (int b = 0; b < nb; b++) begin
                act_a[l][b] = DW'($urandom);
                wgt_a[l][b] = ($urandom_range(0, 1) == 1) ? DW'($urandom) : DW'($urandom_range(0, 1023) - 512);
            end
        end
    endtask

    task automatic drive_beat(input bit first, input bit last, input logic [LANES*DW-1:0] a,
                              input logic [LANES*DW-1:0] w, input logic [LANES*DW-1:0] bs,
                              input bit relu);
        s_valid = 1; s_first = first; s_last = last;
        s_act = a; s_wgt = w; s_bias = bs; relu_en = relu;
        @(posedge clk); #1;
        s_valid = 0; s_first = 0; s_last = 0;
        s_act = '0; s_wgt = '0; s_bias = '0; relu_en = 0;
    endtask

    // restart: the first beat lands mid-accumulation and must raise err.
    // hold: s_valid stays high during the stall and must not be accepted.
    task automatic run_pixel(input string name, input int nb, input bit relu,
                             input int stall, input bit restart, input bit hold);
        logic [LANES*DW-1:0] a, w, bs, exp_d;
        logic exp_sat;
        for (int l = 0; l < LANES; l++) bs[l*DW +: DW] = bias_a[l];
        for (int b = 0; b < nb; b++) begin
            for (int l = 0; l < LANES; l++) begin
                a[l*DW +: DW] = act_a[l][b];
                w[l*DW +: DW] = wgt_a[l][b];
            end
            drive_beat(b == 0, b == nb - 1, a, w, bs, relu);
            if (b == 0) begin
                tests++;
                if (err !== restart) begin
                    fails++;
                    $display("FAIL %s err_first_beat got %0b want %0b", name, err, restart);
                end
            end
        end
        model(nb, relu, exp_d, exp_sat);
        @(posedge clk); #1;
        tests++;
        if (m_valid !== 1'b0 || s_ready !== 1'b0) begin
            fails++;
            $display("FAIL %s after_E1 m_valid=%0b s_ready=%0b want 0/0", name, m_valid, s_ready);
        end
        @(posedge clk); #1;
        tests++;
        if (m_valid !== 1'b1) begin
            fails++;
            $display("FAIL %s latency_E2 m_valid got %0b want 1", name, m_valid);
        end
        tests++;
        if (m_data !== exp_d || m_sat !== exp_sat) begin
            fails++;
            $display("FAIL %s result got %h sat %0b want %h sat %0b", name, m_data, m_sat, exp_d, exp_sat);
        end
        if (hold) begin
            s_valid = 1; s_first = 1; s_last = 1;
        end
        for (int s = 0; s < stall; s++) begin
            @(posedge clk); #1;
            tests++;
            if (m_valid !== 1'b1 || m_data !== exp_d || m_sat !== exp_sat || s_ready !== 1'b0 || err !== 1'b0) begin
                fails++;
                $display("FAIL %s stall%0d m_valid=%0b data=%h s_ready=%0b err=%0b want 1/%h/0/0",
                         name, s, m_valid, m_data, s_ready, err, exp_d);
            end
        end
        s_valid = 0; s_first = 0; s_last = 0;
        m_ready = 1;
        @(posedge clk); #1;
        m_ready = 0;
        tests++;
        if (m_valid !== 1'b0 || s_ready !== 1'b1 || err !== 1'b0) begin
            fails++;
            $display("FAIL %s handshake m_valid=%0b s_ready=%0b err=%0b want 0/1/0", name, m_valid, s_ready, err);
        end
    endtask

    task automatic test_reset;
        rst_n = 0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1;
        @(posedge clk); #1;
        tests++;
        if (s_ready !== 1'b1 || m_valid !== 1'b0 || m_data !== '0 || m_sat !== 1'b0 || err !== 1'b0) begin
            fails++;
            $display("FAIL reset s_ready=%0b m_valid=%0b m_data=%h m_sat=%0b err=%0b want 1/0/0/0/0",
                     s_ready, m_valid, m_data, m_sat, err);
        end
    endtask

    task automatic test_directed;
        fill(1, 16'h0100, 16'h0200, 16'h0000);
        run_pixel("single_beat", 1, 0, 0, 0, 0);
        tests++;
        if (m_data !== {LANES{16'h0200}}) begin
            fails++;
            $display("FAIL single_const got %h want all 0200", m_data);
        end
        fill(9, 16'h0100, 16'h0100, 16'h0080);
        run_pixel("nine_beat", 9, 0, 0, 0, 0);
        tests++;
        if (m_data !== {LANES{16'h0980}}) begin
            fails++;
            $display("FAIL nine_const got %h want all 0980", m_data);
        end
    endtask

    task automatic test_sat_relu;
        fill(4, 16'h7FFF, 16'h7FFF, 16'h0000);
        run_pixel("sat_pos", 4, 0, 0, 0, 0);
        tests++;
        if (m_data !== {LANES{16'h7FFF}} || m_sat !== 1'b1) begin
            fails++;
            $display("FAIL sat_const got %h sat %0b want all 7FFF sat 1", m_data, m_sat);
        end
        fill(1, 16'h0100, 16'hFF00, 16'h0000);
        run_pixel("relu", 1, 1, 0, 0, 0);
        fill(1, 16'h0100, 16'hFF00, 16'h0000);
        run_pixel("no_relu", 1, 0, 0, 0, 0);
        fill(2, 16'h8000, 16'h7FFF, 16'h0000);
        run_pixel("sat_neg", 2, 0, 0, 0, 0);
    endtask

    task automatic test_backpressure;
        fill_rand(5);
        run_pixel("backpressure", 5, 0, 5, 0, 1);
    endtask

    task automatic test_err;
        logic [LANES*DW-1:0] ga, gw, gb;
        for (int l = 0; l < LANES; l++) begin
            ga[l*DW +: DW] = DW'($urandom);
            gw[l*DW +: DW] = DW'($urandom);
            gb[l*DW +: DW] = DW'($urandom);
        end
        drive_beat(0, 0, ga, gw, gb, 0);
        tests++;
        if (err !== 1'b1) begin
            fails++;
            $display("FAIL err_idle_nofirst err got %0b want 1", err);
        end
        @(posedge clk); #1;
        tests++;
        if (err !== 1'b0) begin
            fails++;
            $display("FAIL err_pulse_width err got %0b want 0", err);
        end
        repeat (3) begin
            @(posedge clk); #1;
            tests++;
            if (m_valid !== 1'b0 || s_ready !== 1'b1) begin
                fails++;
                $display("FAIL err_idle_quiet m_valid=%0b s_ready=%0b want 0/1", m_valid, s_ready);
            end
        end
        drive_beat(1, 0, ga, gw, gb, 1);
        drive_beat(0, 0, gw, ga, gb, 1);
        drive_beat(0, 0, ga, ga, gb, 1);
        fill_rand(4);
        run_pixel("restart", 4, 0, 0, 1, 0);
    endtask

    task automatic test_random;
        for (int i = 0; i < 8; i++) begin
            int nb;
            bit relu;
            nb   = $urandom_range(1, 12);
            relu = 1'($urandom_range(0, 1));
            fill_rand(nb);
            run_pixel($sformatf("rand%0d", i), nb, relu, $urandom_range(0, 3), 0, 0);
        end
    endtask

    task automatic test_reset_mid;
        logic [LANES*DW-1:0] a, w, bs;
        fill(9, 16'h0100, 16'h0100, 16'h0080);
        for (int l = 0; l < LANES; l++) begin
            a[l*DW +: DW] = 16'h0100; w[l*DW +: DW] = 16'h0100; bs[l*DW +: DW] = 16'h0080;
        end
        for (int b = 0; b < 4; b++) drive_beat(b == 0, 0, a, w, bs, 0);
        #2 rst_n = 0;
        #1;
        tests++;
        if (m_valid !== 1'b0 || m_data !== '0 || m_sat !== 1'b0 || err !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid m_valid=%0b m_data=%h m_sat=%0b err=%0b want zeros", m_valid, m_data, m_sat, err);
        end
        @(posedge clk); #3 rst_n = 1;
        repeat (4) begin
            @(posedge clk); #1;
            tests++;
            if (s_ready !== 1'b1 || m_valid !== 1'b0) begin
                fails++;
                $display("FAIL reset_release s_ready=%0b m_valid=%0b want 1/0", s_ready, m_valid);
            end
        end
        run_pixel("after_reset", 9, 0, 0, 0, 0);
        tests++;
        if (m_data !== {LANES{16'h0980}}) begin
            fails++;
            $display("FAIL after_reset_const got %h want all 0980", m_data);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_sat_relu();
        test_backpressure();
        test_err();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end
endmodule
